// File: rtl/fixed_int26_6_accumulate_pkg.sv
// rtl/fixed_int26_6_accumulate_pkg.sv - shared 26.6 constants, FSM encoding and saturation helper
package fixed_int26_6_accumulate_pkg;

   localparam int FRAC_BITS = 6;
   localparam logic [31:0] FIXED_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] FIXED_MIN = 32'h8000_0000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_EMIT  = 2'd2;

   localparam logic signed [63:0] SAT_HI = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] SAT_LO = 64'shFFFF_FFFF_8000_0000;

   // Callers sign-extend their wide sum to 64 bits first, so accumulators up to 64 bits are covered.
   function automatic logic [31:0] sat32(input logic signed [63:0] v);
      if (v > SAT_HI)
         return FIXED_MAX;
      else if (v < SAT_LO)
         return FIXED_MIN;
      else
         return v[31:0];
   endfunction

endpackage

// File: rtl/fixed_int26_6_accumulate_if.sv
// rtl/fixed_int26_6_accumulate_if.sv - go/done, length, product and result channels of the accumulator
interface fixed_int26_6_accumulate_if #(parameter int COUNT_WIDTH = 32);

   logic                   goValid;
   logic                   goStop;
   logic                   doneValid;
   logic                   doneStop;
   logic                   lengthReady;
   logic [COUNT_WIDTH-1:0] lengthData;
   logic                   lengthStop;
   logic                   productReady;
   logic [31:0]            productData;
   logic                   productStop;
   logic                   resultReady;
   logic [31:0]            resultData;
   logic                   resultStop;

   modport master (
      output goValid, doneStop, lengthReady, lengthData, productReady, productData, resultStop,
      input  goStop, doneValid, lengthStop, productStop, resultReady, resultData
   );

   modport slave (
      input  goValid, doneStop, lengthReady, lengthData, productReady, productData, resultStop,
      output goStop, doneValid, lengthStop, productStop, resultReady, resultData
   );

endinterface

// File: rtl/fixed_int26_6_accumulate_output_toggle_buffer.sv
// rtl/fixed_int26_6_accumulate_output_toggle_buffer.sv - one-entry output register with ready/stop handshake
module fixed_output_toggle_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             loadValid,
   input  logic [WIDTH-1:0] loadData,
   output logic             outReady,
   output logic [WIDTH-1:0] outData,
   input  logic             outStop
);

   // Producers only load while the buffer is empty, so load and drain never collide.
   always_ff @(posedge clk) begin
      if (srst)
         outReady <= 1'b0;
      else if (loadValid)
         outReady <= 1'b1;
      else if (outReady && !outStop)
         outReady <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (loadValid)
         outData <= loadData;
   end

endmodule

// File: rtl/fixed_int26_6_accumulate.sv
// rtl/fixed_int26_6_accumulate.sv - sums N signed 26.6 products and emits one saturated 26.6 result
module fixed_int26_6_accumulate
   import fixed_int26_6_accumulate_pkg::*;
#(
   parameter int ACC_WIDTH   = 40,
   parameter int COUNT_WIDTH = 32
) (
   input logic clk,
   input logic srst,
   fixed_int26_6_accumulate_if.slave bus
);

   logic [1:0]                  state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic [COUNT_WIDTH-1:0]      remaining;
   logic                        lengthXfer;
   logic                        productXfer;
   logic                        emitLoad;
   logic signed [ACC_WIDTH-1:0] productExt;
   logic [31:0]                 satSum;

   assign bus.doneValid   = bus.goValid;
   assign bus.goStop      = bus.doneStop;
   assign bus.lengthStop  = (state != ST_IDLE);
   assign bus.productStop = (state != ST_ACCUM);

   assign lengthXfer  = bus.lengthReady && !bus.lengthStop;
   assign productXfer = bus.productReady && !bus.productStop;
   assign emitLoad    = (state == ST_EMIT) && !bus.resultReady;
   assign productExt  = ACC_WIDTH'(signed'(bus.productData));
   assign satSum      = sat32(64'(acc));

   always_ff @(posedge clk) begin
      if (srst) begin
         state     <= ST_IDLE;
         acc       <= '0;
         remaining <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (lengthXfer) begin
                  remaining <= bus.lengthData;
                  acc       <= '0;
                  state     <= (bus.lengthData == '0) ? ST_EMIT : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (productXfer) begin
                  acc       <= acc + productExt;
                  remaining <= remaining - COUNT_WIDTH'(1);
                  if (remaining == COUNT_WIDTH'(1))
                     state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               // Stall here until the previous result has drained.
               if (emitLoad)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   fixed_output_toggle_buffer #(.WIDTH(32)) uOutBuf (
      .clk       (clk),
      .srst      (srst),
      .loadValid (emitLoad),
      .loadData  (satSum),
      .outReady  (bus.resultReady),
      .outData   (bus.resultData),
      .outStop   (bus.resultStop)
   );

endmodule

// File: tb/tb_fixed_int26_6_accumulate.sv
// tb/tb_fixed_int26_6_accumulate.sv - directed self-checking bench for the 26.6 accumulator
module tb_fixed_int26_6_accumulate;

   logic clk = 1'b0;
   logic srst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   fixed_int26_6_accumulate_if #(.COUNT_WIDTH(32)) bus ();

   fixed_int26_6_accumulate #(.ACC_WIDTH(40), .COUNT_WIDTH(32)) dut (
      .clk  (clk),
      .srst (srst),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendLength(input logic [31:0] n);
      bit done = 0;
      bus.lengthReady = 1'b1;
      bus.lengthData  = n;
      for (int i = 0; i < 50 && !done; i++) begin
         if (!bus.lengthStop) done = 1;
         tick();
      end
      bus.lengthReady = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL lengthTimeout n=%0d got=stalled want=accepted", n);
      end
   endtask

   task automatic sendProduct(input logic [31:0] d);
      bit done = 0;
      bus.productReady = 1'b1;
      bus.productData  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         if (!bus.productStop) done = 1;
         tick();
      end
      bus.productReady = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL productTimeout d=%h got=stalled want=accepted", d);
      end
   endtask

   task automatic grabResult(output logic [31:0] d, output bit ok);
      ok = 0;
      d  = 'x;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (bus.resultReady) begin
            d  = bus.resultData;
            ok = 1;
         end else begin
            tick();
         end
      end
      if (ok) begin
         bus.resultStop = 1'b0;
         tick();
         bus.resultStop = 1'b1;
      end
   endtask

   task automatic test_reset();
      srst = 1'b1;
      bus.goValid = 1'b0; bus.doneStop = 1'b0;
      bus.lengthReady = 1'b0; bus.lengthData = '0;
      bus.productReady = 1'b0; bus.productData = '0;
      bus.resultStop = 1'b1;
      repeat (3) tick();
      srst = 1'b0;
      tick();
      total++; if (bus.resultReady !== 1'b0) begin bad++; $display("FAIL rstResultReady got=%b want=0", bus.resultReady); end
      total++; if (bus.lengthStop !== 1'b0) begin bad++; $display("FAIL rstLengthStop got=%b want=0", bus.lengthStop); end
      total++; if (bus.productStop !== 1'b1) begin bad++; $display("FAIL rstProductStop got=%b want=1", bus.productStop); end
      bus.goValid = 1'b1; bus.doneStop = 1'b0; #1;
      total++; if (bus.doneValid !== 1'b1 || bus.goStop !== 1'b0) begin bad++; $display("FAIL goDone10 got=%b%b want=10", bus.doneValid, bus.goStop); end
      bus.goValid = 1'b0; bus.doneStop = 1'b1; #1;
      total++; if (bus.doneValid !== 1'b0 || bus.goStop !== 1'b1) begin bad++; $display("FAIL goDone01 got=%b%b want=01", bus.doneValid, bus.goStop); end
      bus.doneStop = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] d;
      bit ok;
      sendLength(3);
      total++; if (bus.lengthStop !== 1'b1 || bus.productStop !== 1'b0) begin bad++; $display("FAIL accumStops got=%b%b want=10", bus.lengthStop, bus.productStop); end
      sendProduct(32'h0000_0040);
      sendProduct(32'h0000_0080);
      sendProduct(32'hFFFF_FFC0);
      total++; if (bus.resultReady !== 1'b0) begin bad++; $display("FAIL basicEarly got=%b want=0", bus.resultReady); end
      tick();
      total++; if (bus.resultReady !== 1'b1) begin bad++; $display("FAIL basicLatency got=%b want=1", bus.resultReady); end
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h0000_0080) begin bad++; $display("FAIL basicSum got=%h ok=%b want=00000080", d, ok); end
      total++; if (bus.resultReady !== 1'b0) begin bad++; $display("FAIL basicDrain got=%b want=0", bus.resultReady); end
   endtask

   task automatic test_zero_length();
      logic [31:0] d;
      bit ok;
      bus.productReady = 1'b1;
      bus.productData  = 32'h0000_1234;
      sendLength(0);
      total++; if (bus.productStop !== 1'b1 || bus.resultReady !== 1'b0) begin bad++; $display("FAIL zeroEmit got=%b%b want=10", bus.productStop, bus.resultReady); end
      tick();
      total++; if (bus.resultReady !== 1'b1 || bus.productStop !== 1'b1) begin bad++; $display("FAIL zeroLatency got=%b%b want=11", bus.resultReady, bus.productStop); end
      bus.productReady = 1'b0;
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h0000_0000) begin bad++; $display("FAIL zeroSum got=%h ok=%b want=00000000", d, ok); end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      bit ok;
      sendLength(2);
      sendProduct(32'h7FFF_FFFF);
      sendProduct(32'h0000_0040);
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h7FFF_FFFF) begin bad++; $display("FAIL satPos got=%h ok=%b want=7fffffff", d, ok); end
      sendLength(2);
      sendProduct(32'h8000_0000);
      sendProduct(32'hFFFF_FFC0);
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h8000_0000) begin bad++; $display("FAIL satNeg got=%h ok=%b want=80000000", d, ok); end
      sendLength(1);
      sendProduct(32'h8000_0000);
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h8000_0000) begin bad++; $display("FAIL satMinExact got=%h ok=%b want=80000000", d, ok); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      bit ok;
      bit heldOk = 1;
      sendLength(1);
      sendProduct(32'h0000_0100);
      sendLength(1);
      sendProduct(32'h0000_0040);
      for (int i = 0; i < 10; i++) begin
         if (bus.resultReady !== 1'b1 || bus.resultData !== 32'h0000_0100 || bus.lengthStop !== 1'b1) heldOk = 0;
         tick();
      end
      total++; if (!heldOk) begin bad++; $display("FAIL b2bHeld got=%b%h%b want=1 00000100 1", bus.resultReady, bus.resultData, bus.lengthStop); end
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h0000_0100) begin bad++; $display("FAIL b2bFirst got=%h ok=%b want=00000100", d, ok); end
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h0000_0040) begin bad++; $display("FAIL b2bSecond got=%h ok=%b want=00000040", d, ok); end
   endtask

   task automatic test_random_ready();
      logic [31:0] d;
      bit ok;
      int sent = 0;
      bit stopsOk = 1;
      sendLength(5);
      for (int i = 0; i < 300 && sent < 5; i++) begin
         bus.productReady = 1'($urandom_range(0, 1));
         bus.productData  = 32'h0000_0010;
         if (bus.lengthStop !== 1'b1 || bus.productStop !== 1'b0) stopsOk = 0;
         if (bus.productReady) sent++;
         tick();
      end
      bus.productReady = 1'b0;
      total++; if (!stopsOk || sent != 5) begin bad++; $display("FAIL randStops got=ok%b sent%0d want=ok1 sent5", stopsOk, sent); end
      total++; if (bus.productStop !== 1'b1) begin bad++; $display("FAIL randNoExtra got=%b want=1", bus.productStop); end
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h0000_0050) begin bad++; $display("FAIL randSum got=%h ok=%b want=00000050", d, ok); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit ok;
      sendLength(4);
      sendProduct(32'h0000_0040);
      sendProduct(32'h0000_0040);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      total++; if (bus.resultReady !== 1'b0 || bus.lengthStop !== 1'b0 || bus.productStop !== 1'b1) begin bad++; $display("FAIL midRst got=%b%b%b want=001", bus.resultReady, bus.lengthStop, bus.productStop); end
      sendLength(1);
      sendProduct(32'h0000_0040);
      grabResult(d, ok);
      total++; if (!ok || d !== 32'h0000_0040) begin bad++; $display("FAIL midRstFresh got=%h ok=%b want=00000040", d, ok); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_length();
      test_saturation();
      test_back_to_back();
      test_random_ready();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
